// File: rtl/pipeline_pkg.sv
// Shared types and default widths for the MEM/WB pipeline register and its skid buffer.
package pipeline_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_W_DEF   = 5;
    localparam int unsigned OPC_W_DEF  = 7;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic                  store_reg;
        logic [RD_W_DEF-1:0]   rd;
        logic [OPC_W_DEF-1:0]  opcode;
    } mem_wb_payload_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_t;

    localparam int unsigned PAYLOAD_W_DEF = $bits(mem_wb_payload_t);

endpackage

// File: rtl/pipeline_skid_buf.sv
// Two-entry valid/ready skid buffer: main entry drives the output, skid entry absorbs overflow.
// in_ready depends only on registered state, so there is no out_ready -> in_ready path.
module pipeline_skid_buf
    import pipeline_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload
);

    skid_state_t          r_state;
    logic [PAYLOAD_W-1:0] r_main;
    logic [PAYLOAD_W-1:0] r_skid;
    logic                 w_in_fire;
    logic                 w_out_fire;

    assign in_ready    = (r_state != StTwo);
    assign out_valid   = (r_state != StEmpty);
    assign out_payload = r_main;
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StEmpty;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            // Held and incoming beats are dropped; main keeps its stale fields.
            r_state <= StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        r_main  <= in_payload;
                        r_state <= StOne;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= in_payload;
                    end else if (w_in_fire) begin
                        r_skid  <= in_payload;
                        r_state <= StTwo;
                    end else if (w_out_fire) begin
                        r_state <= StEmpty;
                    end
                end
                StTwo: begin
                    if (w_out_fire) begin
                        r_main  <= r_skid;
                        r_state <= StOne;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_mem_wb_reg.sv
// MEM/WB pipeline register with valid/ready flow control, flush, x0 write suppression
// and a forwarding tap taken from the entry currently presented to writeback.
module pipeline_mem_wb_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W           = DATA_W_DEF,
    parameter int unsigned RD_W             = RD_W_DEF,
    parameter int unsigned OPC_W            = OPC_W_DEF,
    parameter bit          ZERO_RD_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              store_reg_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [OPC_W-1:0]  opcode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              store_reg_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [OPC_W-1:0]  opcode_out,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned PAYLOAD_W = DATA_W + 1 + RD_W + OPC_W;

    logic [PAYLOAD_W-1:0] w_payload_in;
    logic [PAYLOAD_W-1:0] w_payload_out;
    logic                 w_main_store;
    logic                 w_rd_ok;

    // Field order matches mem_wb_payload_t so default-width payloads line up with the struct.
    assign w_payload_in = {data_in, store_reg_in, rd_in, opcode_in};

    pipeline_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid_buf (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (w_payload_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (w_payload_out)
    );

    assign {data_out, w_main_store, rd_out, opcode_out} = w_payload_out;

    assign w_rd_ok       = !ZERO_RD_SUPPRESS || (rd_out != '0);
    assign store_reg_out = w_main_store & out_valid & w_rd_ok;

    assign fwd_valid = store_reg_out;
    assign fwd_rd    = rd_out;
    assign fwd_data  = data_out;

endmodule

// File: tb/tb_pipeline_mem_wb_reg.sv
// Directed self-checking bench for pipeline_mem_wb_reg; a second instance has x0 suppression off.
module tb_pipeline_mem_wb_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        store_reg_in;
    logic [4:0]  rd_in;
    logic [6:0]  opcode_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic        store_reg_out;
    logic [4:0]  rd_out;
    logic [6:0]  opcode_out;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;

    logic        in_ready_n;
    logic        out_valid_n;
    logic [31:0] data_out_n;
    logic        store_reg_out_n;
    logic [4:0]  rd_out_n;
    logic [6:0]  opcode_out_n;
    logic        fwd_valid_n;
    logic [4:0]  fwd_rd_n;
    logic [31:0] fwd_data_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_mem_wb_reg dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .store_reg_in  (store_reg_in),
        .rd_in         (rd_in),
        .opcode_in     (opcode_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .store_reg_out (store_reg_out),
        .rd_out        (rd_out),
        .opcode_out    (opcode_out),
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
    );

    pipeline_mem_wb_reg #(
        .ZERO_RD_SUPPRESS (1'b0)
    ) dut_nosup (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready_n),
        .data_in       (data_in),
        .store_reg_in  (store_reg_in),
        .rd_in         (rd_in),
        .opcode_in     (opcode_in),
        .out_valid     (out_valid_n),
        .out_ready     (out_ready),
        .data_out      (data_out_n),
        .store_reg_out (store_reg_out_n),
        .rd_out        (rd_out_n),
        .opcode_out    (opcode_out_n),
        .fwd_valid     (fwd_valid_n),
        .fwd_rd        (fwd_rd_n),
        .fwd_data      (fwd_data_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; state moves on the rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic [4:0] r,
                         input logic [6:0] o);
        in_valid     = v;
        data_in      = d;
        store_reg_in = s;
        rd_in        = r;
        opcode_in    = o;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_data_out", data_out, 32'h0);
        check("rst_rd_out", rd_out, 5'd0);
        check("rst_opcode_out", opcode_out, 7'h0);
        check("rst_fwd_valid", fwd_valid, 1'b0);
        rst = 1'b0;

        // Fill to two entries, then reset mid-run.
        drive(1'b1, 32'hAAAA_0001, 1'b1, 5'd9, 7'h13);
        tick();
        drive(1'b1, 32'hAAAA_0002, 1'b1, 5'd10, 7'h13);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("pre_rst_full", in_ready, 1'b0);
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_store", store_reg_out, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_data", data_out, 32'h0);
        rst = 1'b0;

        // Basic beat.
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 5'd5, 7'h33);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("basic_valid", out_valid, 1'b1);
        check("basic_data", data_out, 32'hDEAD_BEEF);
        check("basic_store", store_reg_out, 1'b1);
        check("basic_rd", rd_out, 5'd5);
        check("basic_opc", opcode_out, 7'h33);
        check("basic_fwd_valid", fwd_valid, 1'b1);
        check("basic_fwd_rd", fwd_rd, 5'd5);
        check("basic_fwd_data", fwd_data, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        tick();
        check("basic_drained", out_valid, 1'b0);
        check("basic_drained_fwd", fwd_valid, 1'b0);
        out_ready = 1'b0;

        // Backpressure: A then B held, delivered in order.
        drive(1'b1, 32'h1, 1'b1, 5'd1, 7'h33);
        tick();
        drive(1'b1, 32'h2, 1'b1, 5'd2, 7'h33);
        check("bp_ready_one", in_ready, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("bp_ready_full", in_ready, 1'b0);
        check("bp_head_a", data_out, 32'h1);
        out_ready = 1'b1;
        check("bp_out_ready_no_path", in_ready, 1'b0);
        tick();
        check("bp_b_valid", out_valid, 1'b1);
        check("bp_b_data", data_out, 32'h2);
        check("bp_b_rd", rd_out, 5'd2);
        check("bp_ready_after_a", in_ready, 1'b1);
        tick();
        check("bp_empty", out_valid, 1'b0);

        // Streaming at one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 1'b1, 5'(i + 1), 7'h13);
            if (i > 0) begin
                check("stream_valid", out_valid, 1'b1);
                check("stream_data", data_out, 32'h10 + 32'(i - 1));
                check("stream_in_ready", in_ready, 1'b1);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("stream_last", data_out, 32'h17);
        check("stream_last_valid", out_valid, 1'b1);
        tick();
        check("stream_done", out_valid, 1'b0);
        out_ready = 1'b0;

        // Flush from full with an incoming beat.
        drive(1'b1, 32'hA1, 1'b1, 5'd3, 7'h33);
        tick();
        drive(1'b1, 32'hA2, 1'b1, 5'd4, 7'h33);
        tick();
        check("fl_full", in_ready, 1'b0);
        drive(1'b1, 32'hA3, 1'b1, 5'd6, 7'h33);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("fl_out_valid", out_valid, 1'b0);
        check("fl_in_ready", in_ready, 1'b1);
        check("fl_store", store_reg_out, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_nothing_emerges", out_valid, 1'b0);
        end
        out_ready = 1'b0;

        // x0 write suppression, and the unsuppressed variant.
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd0, 7'h33);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("x0_valid", out_valid, 1'b1);
        check("x0_store", store_reg_out, 1'b0);
        check("x0_fwd_valid", fwd_valid, 1'b0);
        check("x0_data", data_out, 32'hFFFF_FFFF);
        check("x0_nosup_store", store_reg_out_n, 1'b1);
        check("x0_nosup_fwd", fwd_valid_n, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        drive(1'b1, 32'h55, 1'b0, 5'd3, 7'h23);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        check("nostore_store", store_reg_out, 1'b0);
        check("nostore_opc", opcode_out, 7'h23);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Full with no consumer: outputs stay frozen while upstream keeps presenting.
        drive(1'b1, 32'hB1, 1'b1, 5'd7, 7'h03);
        tick();
        drive(1'b1, 32'hB2, 1'b1, 5'd8, 7'h03);
        tick();
        drive(1'b1, 32'hB3, 1'b1, 5'd11, 7'h03);
        for (int i = 0; i < 20; i++) begin
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", data_out, 32'hB1);
            check("hold_rd", rd_out, 5'd7);
            check("hold_store", store_reg_out, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 7'h0);
        out_ready = 1'b1;
        tick();
        check("hold_next_b2", data_out, 32'hB2);
        check("hold_next_rd", rd_out, 5'd8);
        tick();
        check("hold_b3_dropped", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_wb_reg.md
Name: pipeline_mem_wb_reg

Overview:
- Parametrised MEM/WB pipeline register for the RISC-V core, replacing the bare always-load stage register.
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush, asynchronous reset, and x0 write suppression.
- Carries the same payload fields (result data, register-write flag, destination register, opcode).
- Provides a forwarding tap so hazard logic can see the value about to be written back.

Parameters:
- DATA_W, 32, width of result data.
- RD_W, 5, destination register index width.
- OPC_W, 7, opcode width.
- ZERO_RD_SUPPRESS, 1, when 1 the write flag is forced low for rd==0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous discard of all held and incoming beats.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat.
- data_in  input  DATA_W  result data.
- store_reg_in  input  1  register-file write request.
- rd_in  input  RD_W  destination register.
- opcode_in  input  OPC_W  instruction opcode.
- out_valid  output  1  writeback beat present.
- out_ready  input  1  writeback consumes the beat.
- data_out  output  DATA_W  held data.
- store_reg_out  output  1  gated write enable.
- rd_out  output  RD_W  held destination.
- opcode_out  output  OPC_W  held opcode.
- fwd_valid  output  1  forwarding tap valid.
- fwd_rd  output  RD_W  forwarding register index.
- fwd_data  output  DATA_W  forwarding data.

Behaviour:
- Reset (rst high, async):
  - state EMPTY; main and skid entries cleared to 0.
  - out_valid=0, store_reg_out=0, data_out=0, rd_out=0, opcode_out=0, fwd_valid=0.
  - in_ready=1 (derived from the empty skid entry); no beat is captured while rst is high.
  - Reset mid-transfer drops all beats; no partial beat survives.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !skid_valid, from registered state only; no combinational path from out_ready.
  - out_valid = main_valid.
- State machine (main entry drives the outputs; skid entry is the overflow):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire & !out_fire -> TWO, skid<=in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: in_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid when empty.
  - Sustains 1 beat/cycle while out_ready=1.
  - Ordering is strictly FIFO.
- Flush:
  - Highest priority below rst; next state EMPTY.
  - A beat presented in the flush cycle is accepted (if in_ready) and discarded.
  - out_fire in the flush cycle still counts as consumed; the writeback commit that cycle is permitted.
- Output gating:
  - store_reg_out = main_store & main_valid & (ZERO_RD_SUPPRESS ? rd_out!=0 : 1).
  - data_out, rd_out and opcode_out hold the last main values when out_valid=0. Consumers must qualify them with out_valid.
- Forwarding tap (combinational from the main entry):
  - fwd_valid = store_reg_out.
  - fwd_rd = rd_out.
  - fwd_data = data_out.
  - The skid entry is never forwarded; upstream hazard logic stalls while in_ready=0.
- Boundaries:
  - Full (TWO) with out_ready=0: hold indefinitely with stable outputs.
  - in_valid while full: not accepted; upstream must hold the beat.
  - Widths: no arithmetic; all fields pass through unmodified.

Decomposition:
- Package pipeline_pkg holds:
  - DATA_W/RD_W/OPC_W defaults.
  - Packed struct mem_wb_payload_t {data, store_reg, rd, opcode}.
  - Enum skid_state_t {EMPTY, ONE, TWO}.
- Sub-module pipeline_skid_buf (parameter PAYLOAD_W) implements the state machine, the two entries and flush.
- The top level packs/unpacks the payload and applies write gating and the forwarding tap.

Test Plan:
- Reset and basic flow: assert rst mid-run with beats held -> next cycle out_valid=0, store_reg_out=0, in_ready=1. After release, beat {data=0xDEADBEEF, store=1, rd=5, opc=0x33} -> out_valid=1 one cycle later with identical fields, fwd_valid=1, fwd_rd=5.
- Backpressure: out_ready=0, send beats A=0x1, B=0x2 on consecutive cycles -> in_ready=0 after B. Raise out_ready -> A then B delivered in order on consecutive cycles, in_ready=1 again after A leaves.
- Streaming: out_ready=1, 8 consecutive beats 0x10..0x17 -> 8 consecutive out_fire cycles, in order, state never TWO.
- Flush: fill to TWO, assert flush one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, no flushed beat ever appears.
- x0 suppression: beat rd=0, store=1, data=0xFFFF_FFFF -> out_valid=1, store_reg_out=0, fwd_valid=0. With ZERO_RD_SUPPRESS=0 -> store_reg_out=1.
- Hold stability: TWO state with out_ready=0 for 20 cycles -> all outputs constant, in_ready=0 throughout.
